// File: rtl/softusb_crcgen.sv
// softusb_crcgen -- USB CRC5/CRC16 checker and optional CRC appender.
//
// Absorbs DW bits per crc_ce beat (data[0] earliest on the wire) into an
// MSB-first CRC register and flags crc_ok when the register matches the
// USB residual for the mode latched at crc_clear.
//
// Build option: define SOFTUSB_CRCGEN_TX_EN to compile the append path
// (tx_start / tx_valid / tx_ready / tx_data / tx_last and the overrun flag).
// Without it the tx outputs are tied to 0, tx_start is ignored and overrun
// stays 0.
//
// tx handshake: while tx_valid is high, tx_data/tx_last describe the current
// beat; the beat is consumed on the rising edge where tx_valid && tx_ready,
// and tx_data/tx_last stay stable until that edge.
//
// o_dbg_state exposes the FSM state (0 = IDLE, 1 = APPEND, 2 = DONE).
module softusb_crcgen #(
  parameter int DW   = 1,
  parameter int CNTW = 16
) (
  input  logic            usb_clk,
  input  logic            usb_rst,
  input  logic            crc_clear,
  input  logic            sel16,
  input  logic            crc_ce,
  input  logic [DW-1:0]   data,
  input  logic            tx_start,
  input  logic            tx_ready,
  output logic            tx_valid,
  output logic [DW-1:0]   tx_data,
  output logic            tx_last,
  output logic            crc_ok,
  output logic [15:0]     crc_value,
  output logic [CNTW-1:0] bit_count,
  output logic            overrun,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPEND = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic            r_sel16;
  logic [15:0]     r_crc;
  logic [CNTW-1:0] r_cnt;
  logic            r_overrun;
  state_t          r_state;

  logic [15:0]     w_fold;
  logic            w_fb;
  logic [CNTW:0]   w_cnt_sum;
  logic [CNTW-1:0] w_cnt_next;

  // Fold the DW beat bits into the register, earliest bit (data[0]) first.
  // In CRC5 mode the upper 11 register bits are kept at zero.
  always_comb begin
    w_fold = r_crc;
    w_fb   = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (r_sel16) begin
        w_fb   = data[i] ^ w_fold[15];
        w_fold = {w_fold[14:0], 1'b0} ^ (w_fb ? 16'h8005 : 16'h0000);
      end else begin
        w_fb   = data[i] ^ w_fold[4];
        w_fold = {11'd0, w_fold[3:0], 1'b0} ^ (w_fb ? 16'h0005 : 16'h0000);
      end
    end
  end

  // Bit counter advances by DW and sticks at all-ones instead of wrapping.
  assign w_cnt_sum  = {1'b0, r_cnt} + (CNTW+1)'(DW);
  assign w_cnt_next = w_cnt_sum[CNTW] ? '1 : w_cnt_sum[CNTW-1:0];

`ifdef SOFTUSB_CRCGEN_TX_EN
  // Remaining complemented CRC bits, MSB-aligned; zeros shift in from below
  // so the final beat comes out zero-padded in its upper bits.
  logic [15:0] r_shift;
  logic [4:0]  r_bits_left;
  logic [15:0] w_load;
  logic        w_tx_fire;

  // A beat arriving together with tx_start is folded before the snapshot.
  assign w_load    = crc_ce ? w_fold : r_crc;
  assign w_tx_fire = tx_valid && tx_ready;
  assign tx_valid  = (r_state == APPEND);
  assign tx_last   = tx_valid && (r_bits_left <= 5'(DW));

  // Present the next DW bits of the shift register, earliest bit in tx_data[0].
  always_comb begin
    tx_data = '0;
    if (r_state == APPEND) begin
      for (int j = 0; j < DW; j++) begin
        tx_data[j] = r_shift[15-j];
      end
    end
  end
`else
  logic w_unused_tx;

  assign w_unused_tx = &{1'b0, tx_start, tx_ready};
  assign tx_valid    = 1'b0;
  assign tx_last     = 1'b0;
  assign tx_data     = '0;
`endif

  // Main state: reset, then clear, then per-state beat / append handling.
  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      r_sel16     <= 1'b0;
      r_crc       <= 16'h001F;
      r_cnt       <= '0;
      r_overrun   <= 1'b0;
      r_state     <= IDLE;
`ifdef SOFTUSB_CRCGEN_TX_EN
      r_shift     <= '0;
      r_bits_left <= '0;
`endif
    end else if (crc_clear) begin
      r_sel16     <= sel16;
      r_crc       <= sel16 ? 16'hFFFF : 16'h001F;
      r_cnt       <= '0;
      r_overrun   <= 1'b0;
      r_state     <= IDLE;
`ifdef SOFTUSB_CRCGEN_TX_EN
      r_shift     <= '0;
      r_bits_left <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (crc_ce) begin
            r_crc <= w_fold;
            r_cnt <= w_cnt_next;
          end
`ifdef SOFTUSB_CRCGEN_TX_EN
          if (tx_start) begin
            r_state     <= APPEND;
            r_shift     <= r_sel16 ? ~w_load : {~w_load[4:0], 11'd0};
            r_bits_left <= r_sel16 ? 5'd16 : 5'd5;
          end
`endif
        end
        APPEND: begin
`ifdef SOFTUSB_CRCGEN_TX_EN
          if (crc_ce) begin
            r_overrun <= 1'b1;
          end
          if (w_tx_fire) begin
            r_shift <= r_shift << DW;
            if (tx_last) begin
              r_bits_left <= '0;
              r_state     <= DONE;
            end else begin
              r_bits_left <= r_bits_left - 5'(DW);
            end
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign crc_ok      = r_sel16 ? (r_crc == 16'h800D) : (r_crc[4:0] == 5'b01100);
  assign crc_value   = r_crc;
  assign bit_count   = r_cnt;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule
